qoi_frame_arbiter: RTL
======================

QOI_FRAME_ARBITER -- requirements
Module: qoi_frame_arbiter

Interface
REQ-001 The block SHALL have parameter RR, default 1, meaning 1 = round-robin between channels and 0 = fixed priority to channel 0.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state updates on its rising edge.
REQ-003 The block SHALL have port rstn, input, 1, reset, asynchronous and active-low.
REQ-004 The block SHALL have ports s0_tvalid/s1_tvalid, input, 1 each, pixel beat valid from channel 0/1.
REQ-005 The block SHALL have ports s0_tready/s1_tready, output, 1 each, pixel beat accepted from channel 0/1.
REQ-006 The block SHALL have ports s0_tlast/s1_tlast, input, 1 each, last pixel of frame.
REQ-007 The block SHALL have ports s0_R/G/B and s1_R/G/B, input, 8 each, pixel colour.
REQ-008 The block SHALL have ports s0_width/s0_height and s1_width/s1_height, input, 32 each, frame size, valid with every beat.
REQ-009 The block SHALL have port m_tvalid, output, 1, output beat valid.
REQ-010 The block SHALL have port m_tready, input, 1, sink accepts beat.
REQ-011 The block SHALL have ports m_tlast, output, 1, and m_R/m_G/m_B, output, 8 each, forwarded beat.
REQ-012 The block SHALL have ports m_width/m_height, output, 32 each, size latched at the frame's first beat.
REQ-013 The block SHALL have port m_src, output, 1, channel that owns the current output beat.
REQ-014 The block SHALL have port frame_err, output, 1, one-cycle pulse for a frame-length mismatch.
REQ-015 The block SHALL have port frame_cnt, output, 16, count of completed output frames, wrapping at 65535->0.

Function
REQ-016 The FSM SHALL have two states: IDLE (no grant, s0_tready=s1_tready=0) and BUSY (one channel granted).
REQ-017 In IDLE, any sX_tvalid=1 SHALL move the FSM to BUSY on the next edge, latching grant g.
REQ-018 Grant selection SHALL be: the only valid channel; if both are valid and RR=1, the channel not served last (channel 0 after reset); if both are valid and RR=0, channel 0.
REQ-019 In BUSY, sg_tready SHALL equal (!m_tvalid | m_tready), and the non-granted tready SHALL be 0.
REQ-020 An accepted beat (sg_tvalid & sg_tready) SHALL load the output register: m_tvalid=1, with m_tlast/m_R/G/B/m_src from the beat; latency exactly one cycle.
REQ-021 The output register SHALL clear m_tvalid when m_tready=1 and no new beat is accepted; while m_tready=0 all m_* outputs SHALL stay stable.
REQ-022 On the first accepted beat of a frame, width/height SHALL be latched into m_width/m_height, and the pixel counter SHALL load 1; each later accepted beat SHALL increment it by 1 (32-bit).
REQ-023 An accepted beat with sg_tlast=1 SHALL return the FSM to IDLE, record g as last-served, and increment frame_cnt on the same edge.
REQ-024 frame_err SHALL pulse high for one cycle after an accepted tlast beat whose counter value (including that beat) differs from the low 32 bits of latched width*height.
REQ-025 The grant SHALL never change between the first beat and the tlast beat of a frame, regardless of the other channel's tvalid.
REQ-026 A frame consisting of a single beat (tlast on its first beat) SHALL be legal, with the expected count 1.
REQ-027 A new grant SHALL be taken in IDLE while the previous frame's last beat is still held in the output register (m_tvalid=1, m_tready=0), with no lost or reordered beat.

Reset
REQ-028 rstn=0 SHALL immediately force IDLE, m_tvalid=0, m_tlast=0, m_R/G/B=0, m_width=m_height=0, m_src=0, frame_err=0, frame_cnt=0, counter=0, last-served=1, and both tready=0.
REQ-029 Reset asserted mid-frame SHALL discard the partial frame; after release, arbitration SHALL restart from IDLE.

Verification
REQ-030 Single-channel frame: s0 sends a 4x2 image as 8 beats with tlast on beat 8 and m_tready=1 -> 8 output beats, one cycle delayed, m_src=0, m_width=4, m_height=2, frame_cnt=1, frame_err=0.
REQ-031 Round-robin contention: both channels hold 2x2 frames valid continuously with RR=1 -> output frame order ch0, ch1, ch0, ch1 with no interleaved beats; with RR=0 -> ch0 only while ch0 stays valid.
REQ-032 Backpressure: random m_tready at 50% during a 3x3 frame -> all 9 pixels delivered in order, m_* stable while stalled, no beat duplicated.
REQ-033 Length error: a 2x2 frame with tlast on beat 3 -> frame_err pulses once; a 1x1 frame with tlast on beat 1 -> no error.
REQ-034 Reset mid-frame: rstn=0 after beat 2 of 4 -> outputs at reset values; the next frame from s1 is granted and completes with frame_cnt=1.

Source files
------------

// File: rtl/qoi_frame_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : qoi_frame_arbiter
// Purpose  : Two-channel pixel-stream arbiter. A grant is held for a whole frame.
//            Frame length is checked against width*height.
// Revision : 1.0 - initial release
// ============================================================================
module qoi_frame_arbiter #(
    parameter int RR = 1
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        s0_tvalid,
    output logic        s0_tready,
    input  logic        s0_tlast,
    input  logic [7:0]  s0_R,
    input  logic [7:0]  s0_G,
    input  logic [7:0]  s0_B,
    input  logic [31:0] s0_width,
    input  logic [31:0] s0_height,
    input  logic        s1_tvalid,
    output logic        s1_tready,
    input  logic        s1_tlast,
    input  logic [7:0]  s1_R,
    input  logic [7:0]  s1_G,
    input  logic [7:0]  s1_B,
    input  logic [31:0] s1_width,
    input  logic [31:0] s1_height,
    output logic        m_tvalid,
    input  logic        m_tready,
    output logic        m_tlast,
    output logic [7:0]  m_R,
    output logic [7:0]  m_G,
    output logic [7:0]  m_B,
    output logic [31:0] m_width,
    output logic [31:0] m_height,
    output logic        m_src,
    output logic        frame_err,
    output logic [15:0] frame_cnt
);

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } state_t;

    state_t      r_state;
    logic        r_grant;
    logic        r_last_served;
    logic        r_first;
    logic [31:0] r_pix_cnt;

    logic        w_room;
    logic        w_accept;
    logic        w_pick;
    logic        w_g_last;
    logic [7:0]  w_g_r;
    logic [7:0]  w_g_g;
    logic [7:0]  w_g_b;
    logic [31:0] w_g_width;
    logic [31:0] w_g_height;
    logic [31:0] w_cnt_next;
    logic [31:0] w_frame_w;
    logic [31:0] w_frame_h;
    logic [31:0] w_area;

    // The output register can take a beat when empty or draining this cycle.
    assign w_room     = !m_tvalid || m_tready;
    assign s0_tready  = (r_state == ST_BUSY) && !r_grant && w_room;
    assign s1_tready  = (r_state == ST_BUSY) &&  r_grant && w_room;
    assign w_accept   = (s0_tvalid && s0_tready) || (s1_tvalid && s1_tready);

    assign w_g_last   = r_grant ? s1_tlast  : s0_tlast;
    assign w_g_r      = r_grant ? s1_R      : s0_R;
    assign w_g_g      = r_grant ? s1_G      : s0_G;
    assign w_g_b      = r_grant ? s1_B      : s0_B;
    assign w_g_width  = r_grant ? s1_width  : s0_width;
    assign w_g_height = r_grant ? s1_height : s0_height;

    always_comb begin
        w_pick = s1_tvalid;
        if (s0_tvalid && s1_tvalid) begin
            w_pick = (RR != 0) ? !r_last_served : 1'b0;
        end
    end

    // On the first beat the size is not latched yet, so use the live inputs.
    assign w_cnt_next = r_first ? 32'd1 : r_pix_cnt + 32'd1;
    assign w_frame_w  = r_first ? w_g_width  : m_width;
    assign w_frame_h  = r_first ? w_g_height : m_height;
    assign w_area     = w_frame_w * w_frame_h;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_grant       <= 1'b0;
            r_last_served <= 1'b1;
            r_first       <= 1'b0;
            r_pix_cnt     <= 32'd0;
            m_tvalid      <= 1'b0;
            m_tlast       <= 1'b0;
            m_R           <= 8'd0;
            m_G           <= 8'd0;
            m_B           <= 8'd0;
            m_width       <= 32'd0;
            m_height      <= 32'd0;
            m_src         <= 1'b0;
            frame_err     <= 1'b0;
            frame_cnt     <= 16'd0;
        end else begin
            frame_err <= 1'b0;

            if (w_accept) begin
                m_tvalid <= 1'b1;
                m_tlast  <= w_g_last;
                m_R      <= w_g_r;
                m_G      <= w_g_g;
                m_B      <= w_g_b;
                m_src    <= r_grant;
            end else if (m_tready) begin
                m_tvalid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (s0_tvalid || s1_tvalid) begin
                        r_state <= ST_BUSY;
                        r_grant <= w_pick;
                        r_first <= 1'b1;
                    end
                end
                ST_BUSY: begin
                    if (w_accept) begin
                        r_first   <= 1'b0;
                        r_pix_cnt <= w_cnt_next;
                        if (r_first) begin
                            m_width  <= w_g_width;
                            m_height <= w_g_height;
                        end
                        if (w_g_last) begin
                            r_state       <= ST_IDLE;
                            r_last_served <= r_grant;
                            frame_cnt     <= frame_cnt + 16'd1;
                            frame_err     <= (w_cnt_next != w_area);
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
